// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES constants, types and GF(2^8) helpers
package aes_pkg;

   localparam int unsigned NB = 4;
   localparam int unsigned NK = 4;
   localparam int unsigned NR = 10;

   typedef logic [31:0]        word_t;
   typedef logic [NK*32-1:0]   block_t;

   typedef enum logic {
      IDLE,
      EMIT
   } state_t;

   // Round constant bytes, entry 0 unused
   localparam logic [7:0] RC [0:10] = '{
      8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
      8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
   };

   function automatic logic [7:0] rc_byte(input logic [3:0] r);
      logic [7:0] v;
      v = 8'h00;
      if (r <= 4'd10) v = RC[r];
      return v;
   endfunction

   // Multiplication modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

endpackage

// File: rtl/key_exp128_inv_if.sv
// rtl/key_exp128_inv_if.sv - load/stream bundle of the reverse key schedule
interface key_exp128_inv_if;
   import aes_pkg::*;

   logic       start;
   block_t     last_key;
   block_t     rk;
   logic [3:0] rk_idx;
   logic       rk_valid;
   logic       rk_ready;
   logic       busy;
   logic       done;

   modport master (
      output start, last_key, rk_ready,
      input  rk, rk_idx, rk_valid, busy, done
   );

   modport slave (
      input  start, last_key, rk_ready,
      output rk, rk_idx, rk_valid, busy, done
   );

endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - AES forward S-box, combinational
module aes_sbox
   import aes_pkg::*;
(
   input  logic [7:0] din,
   output logic [7:0] dout
);

   logic [7:0] x2, x3, x12, x15, x240, x252, inv;

   // Inverse as x^254 through a short addition chain; maps 0 to 0
   always_comb begin
      x2   = gf_mul(din, din);
      x3   = gf_mul(x2, din);
      x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
      x15  = gf_mul(x12, x3);
      x240 = gf_mul(x15, x15);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x240 = gf_mul(x240, x240);
      x252 = gf_mul(x240, x12);
      inv  = gf_mul(x252, x2);
   end

   assign dout = inv
               ^ {inv[6:0], inv[7]}
               ^ {inv[5:0], inv[7:6]}
               ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]}
               ^ 8'h63;

endmodule

// File: rtl/key_exp128_inv.sv
// rtl/key_exp128_inv.sv - reverse AES-128 key schedule, round NR down to 0
module key_exp128_inv
   import aes_pkg::*;
#(
   parameter int unsigned NR = aes_pkg::NR
) (
   input  logic           clk,
   input  logic           rst,
   key_exp128_inv_if.slave bus
);

   state_t     state;
   block_t     key_reg;
   logic [3:0] r;
   logic       done_q;

   word_t w0, w1, w2, w3;
   word_t p0, p1, p2, p3;
   word_t rot, sub;
   logic  fire;

   assign w0 = key_reg[127:96];
   assign w1 = key_reg[95:64];
   assign w2 = key_reg[63:32];
   assign w3 = key_reg[31:0];

   assign p3 = w3 ^ w2;
   assign p2 = w2 ^ w1;
   assign p1 = w1 ^ w0;
   assign rot = {p3[23:0], p3[31:24]};

   for (genvar i = 0; i < NB; i++) begin : g_sub
      aes_sbox u_sbox (
         .din  (rot[8*i +: 8]),
         .dout (sub[8*i +: 8])
      );
   end

   // Rebuilt first word uses the round constant of the key being undone
   assign p0 = w0 ^ sub ^ {rc_byte(r), 24'h000000};

   assign fire = (state == EMIT) && bus.rk_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         key_reg <= '0;
         r       <= 4'd0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  key_reg <= bus.last_key;
                  r       <= 4'(NR);
                  state   <= EMIT;
               end
            end
            EMIT: begin
               if (fire) begin
                  if (r != 4'd0) begin
                     key_reg <= {p0, p1, p2, p3};
                     r       <= r - 4'd1;
                  end else begin
                     state  <= IDLE;
                     done_q <= 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.rk       = key_reg;
   assign bus.rk_idx   = r;
   assign bus.rk_valid = (state == EMIT);
   assign bus.busy     = (state != IDLE);
   assign bus.done     = done_q;

endmodule

// File: tb/tb_key_exp128_inv.sv
// tb/tb_key_exp128_inv.sv - directed vector bench for key_exp128_inv
module tb_key_exp128_inv;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_errors;

   logic [127:0] exp_k  [0:10];
   bit           exp_ok [0:10];

   localparam logic [127:0] A1_10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] Z_10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

   key_exp128_inv_if bus ();

   key_exp128_inv #(.NR(10)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic load_a1();
      exp_k[10] = A1_10;
      exp_k[9]  = 128'hac7766f319fadc2128d12941575c006e;
      exp_k[8]  = 128'head27321b58dbad2312bf5607f8d292f;
      exp_k[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
      exp_k[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
      exp_k[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
      exp_k[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
      exp_k[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
      exp_k[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
      exp_k[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
      exp_k[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
      for (int i = 0; i <= 10; i++) exp_ok[i] = 1'b1;
   endtask

   task automatic load_zero();
      for (int i = 0; i <= 10; i++) exp_ok[i] = 1'b0;
      exp_k[10] = Z_10;                                  exp_ok[10] = 1'b1;
      exp_k[1]  = 128'h62636363626363636263636362636363; exp_ok[1]  = 1'b1;
      exp_k[0]  = 128'h0;                                exp_ok[0]  = 1'b1;
   endtask

   // Called at a negedge; returns at the negedge after start was sampled
   task automatic start_key(input logic [127:0] key);
      bus.start    = 1'b1;
      bus.last_key = key;
      @(negedge clk);
      bus.start    = 1'b0;
   endtask

   task automatic drain(input int stall_pct, input int inject_at, input int abort_at,
                        input bit check_lat);
      int           idx_exp;
      int           cyc;
      bit           stalled;
      bit           rdy;
      logic [127:0] hold_rk;
      logic [3:0]   hold_idx;
      idx_exp = 10;
      cyc     = 0;
      stalled = 1'b0;
      while (idx_exp >= 0) begin
         if (cyc >= 400) begin
            check("timeout_keys_left", 128'(idx_exp + 1), 128'd0);
            return;
         end
         if (stalled) begin
            check("stall_rk", bus.rk, hold_rk);
            check("stall_idx", 128'(bus.rk_idx), 128'(hold_idx));
         end
         check("valid", 128'(bus.rk_valid), 128'd1);
         if (idx_exp == abort_at) begin
            bus.rk_ready = 1'b0;
            rst = 1'b1;
            #1;
            check("rst_rk", bus.rk, 128'd0);
            check("rst_idx", 128'(bus.rk_idx), 128'd0);
            check("rst_valid", 128'(bus.rk_valid), 128'd0);
            check("rst_busy", 128'(bus.busy), 128'd0);
            check("rst_done", 128'(bus.done), 128'd0);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         bus.start = (idx_exp == inject_at);
         if (idx_exp == inject_at) bus.last_key = Z_10;
         rdy = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
         bus.rk_ready = rdy;
         if (rdy) begin
            check($sformatf("idx_%0d", idx_exp), 128'(bus.rk_idx), 128'(idx_exp));
            if (exp_ok[idx_exp]) check($sformatf("rk_%0d", idx_exp), bus.rk, exp_k[idx_exp]);
            idx_exp--;
         end
         stalled  = !rdy;
         hold_rk  = bus.rk;
         hold_idx = bus.rk_idx;
         @(negedge clk);
         bus.start = 1'b0;
         cyc++;
      end
      check("done", 128'(bus.done), 128'd1);
      check("done_busy", 128'(bus.busy), 128'd0);
      check("done_valid", 128'(bus.rk_valid), 128'd0);
      if (check_lat) check("done_latency", 128'(cyc), 128'd11);
   endtask

   initial begin
      n_checks     = 0;
      n_errors     = 0;
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.last_key = '0;
      bus.rk_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_rk", bus.rk, 128'd0);
      check("reset_idx", 128'(bus.rk_idx), 128'd0);
      check("reset_valid", 128'(bus.rk_valid), 128'd0);
      check("reset_busy", 128'(bus.busy), 128'd0);
      check("reset_done", 128'(bus.done), 128'd0);
      rst = 1'b0;
      @(negedge clk);

      load_a1();
      start_key(A1_10);
      drain(0, -1, -1, 1'b1);

      load_zero();
      start_key(Z_10);
      check("b2b_busy", 128'(bus.busy), 128'd1);
      drain(0, -1, -1, 1'b1);
      @(negedge clk);

      load_a1();
      start_key(A1_10);
      drain(50, -1, -1, 1'b0);
      @(negedge clk);

      start_key(A1_10);
      drain(0, 5, -1, 1'b0);
      @(negedge clk);

      start_key(A1_10);
      drain(0, -1, 4, 1'b0);
      start_key(A1_10);
      drain(0, -1, -1, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
